mem_ctrl: RTL and testbench

//  Word-addressed RAM plus access controller feeding the datapath's m_data_in; the datapath's MDR register captures m_data_in.

---
 rtl/mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Word-addressed RAM with a request controller. It adds wait
//                states, then reports completion with a one-cycle mem_done.
//                Optional MEM_ALIGN_CHECK_EN rejects addresses that are not
//                word-aligned.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] mar_addr,
    input  logic [DATA_WIDTH-1:0] mdr_data,
    input  logic                  read_req,
    input  logic                  write_req,
    output logic [DATA_WIDTH-1:0] m_data_in,
    output logic                  mem_done,
    output logic                  mem_busy,
    output logic                  mem_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [7:0]              cnt_q,      cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic                    is_write_q, is_write_d;
    logic                    err_q,      err_d;
    logic [DATA_WIDTH-1:0]   m_data_q,   m_data_d;
    logic                    mem_done_q, mem_done_d;
    logic                    mem_busy_q, mem_busy_d;
    logic                    mem_err_q,  mem_err_d;

    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    logic w_range_err;
    logic w_align_err;
    logic w_req_err;
    logic w_access;
    logic w_ram_we;

    assign w_range_err = |mar_addr[DATA_WIDTH-1:ADDR_WIDTH+2];
`ifdef MEM_ALIGN_CHECK_EN
    assign w_align_err = |mar_addr[1:0];
`else
    // Byte-offset bits are read but never allowed to raise an error.
    assign w_align_err = (|mar_addr[1:0]) & 1'b0;
`endif
    assign w_req_err = (read_req & write_req) | w_range_err | w_align_err;

    assign w_access = (state_q == ST_WAIT) && (cnt_q == 8'd0);
    assign w_ram_we = w_access && is_write_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        m_data_d   = m_data_q;

        case (state_q)
            ST_IDLE: begin
                if (read_req | write_req) begin
                    addr_d     = mar_addr[ADDR_WIDTH+1:2];
                    wdata_d    = mdr_data;
                    is_write_d = write_req;
                    err_d      = w_req_err;
                    cnt_d      = 8'(WAIT_STATES);
                    state_d    = w_req_err ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    if (!is_write_q) begin
                        m_data_d = ram[addr_q];
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion is reported on the edge that leaves DONE, so the pulse
        // lands one edge after the access (or after the rejected sample).
        mem_done_d = (state_q == ST_DONE);
        mem_err_d  = (state_q == ST_DONE) && err_q;
        mem_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            m_data_q   <= '0;
            mem_done_q <= 1'b0;
            mem_busy_q <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
            m_data_q   <= m_data_d;
            mem_done_q <= mem_done_d;
            mem_busy_q <= mem_busy_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // RAM has no reset; an aborted write never fires because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            ram[addr_q] <= wdata_q;
        end
    end

    assign m_data_in = m_data_q;
    assign mem_done  = mem_done_q;
    assign mem_busy  = mem_busy_q;
    assign mem_err   = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Scoreboard bench for mem_ctrl with a word-array reference
//                model, directed corner cases and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int WS    = 1;
    localparam int DEPTH = 2 ** AW;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] mar_addr;
    logic [DW-1:0] mdr_data;
    logic          read_req;
    logic          write_req;
    logic [DW-1:0] m_data_in;
    logic          mem_done;
    logic          mem_busy;
    logic          mem_err;

    mem_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_STATES(WS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mar_addr (mar_addr),
        .mdr_data (mdr_data),
        .read_req (read_req),
        .write_req(write_req),
        .m_data_in(m_data_in),
        .mem_done (mem_done),
        .mem_busy (mem_busy),
        .mem_err  (mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            k;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] last_read;
    int            checks = 0;
    int            errors = 0;
    int            words[16];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (mem_done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: mem_done=1 with no request outstanding (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_err", {31'd0, mem_err}, {31'd0, e.err});
                check("done_data", m_data_in, e.data);
                check("done_latency", cyc - e.k, e.err ? 1 : WS + 2);
            end
        end
    end

    task automatic do_op(input logic rd, input logic wr, input logic [DW-1:0] addr,
                         input logic [DW-1:0] data, input bit poke);
        exp_t e;
        bit   err;
        int   word;
        int   n;
        err  = (rd && wr) || (addr >= DW'(4 * DEPTH)) || (ALIGN && (addr % 4 != 0));
        word = int'(addr / 4);
        if (!err && rd) begin
            last_read = model_mem.exists(word) ? model_mem[word] : 'x;
        end
        if (!err && wr) begin
            model_mem[word] = data;
        end
        e.err  = err;
        e.data = last_read;

        @(negedge clk);
        read_req  = rd;
        write_req = wr;
        mar_addr  = addr;
        mdr_data  = data;
        @(posedge clk);
        #1;
        e.k       = cyc;
        read_req  = 1'b0;
        write_req = 1'b0;
        mar_addr  = $urandom;
        mdr_data  = $urandom;
        sb.push_back(e);

        @(negedge clk);
        check("busy_after_req", {31'd0, mem_busy}, 32'd1);
        if (poke) begin
            read_req = 1'b1;
            @(posedge clk);
            #1;
            read_req = 1'b0;
        end
        n = 0;
        while (mem_done !== 1'b1 && n < WS + 20) begin
            @(negedge clk);
            n++;
        end
        if (mem_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no mem_done within %0d cycles (t=%0t)", WS + 20, $time);
        end
    endtask

    initial begin
        reset     = 1'b1;
        read_req  = 1'b0;
        write_req = 1'b0;
        mar_addr  = '0;
        mdr_data  = '0;
        last_read = '0;
        #1;
        check("rst_data", m_data_in, 32'd0);
        check("rst_ctrl", {29'd0, mem_done, mem_busy, mem_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Write then read back.
        do_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Out-of-range write must not alias onto word 0.
        do_op(1'b0, 1'b1, 32'h0, 32'hA5A5_5A5A, 1'b0);
        do_op(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        do_op(1'b0, 1'b1, 32'h800, 32'h12345678, 1'b0);
        do_op(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Conflicting request, then a read with a stray read_req while busy.
        do_op(1'b1, 1'b1, 32'h10, 32'h0BAD_0BAD, 1'b0);
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        do_op(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);

        // Reset while a write waits: write aborted, outputs cleared at once.
        do_op(1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0);
        @(negedge clk);
        write_req = 1'b1;
        mar_addr  = 32'h20;
        mdr_data  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        write_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_data", m_data_in, 32'd0);
        check("async_rst_ctrl", {29'd0, mem_done, mem_busy, mem_err}, 32'd0);
        last_read = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_op(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Random traffic over a small, pre-initialised set of words.
        for (int i = 0; i < 16; i++) begin
            words[i] = int'($urandom_range(0, DEPTH - 1));
            do_op(1'b0, 1'b1, DW'(words[i] * 4), $urandom, 1'b0);
        end
        for (int i = 0; i < 150; i++) begin
            int            r;
            logic [DW-1:0] a;
            r = int'($urandom_range(0, 99));
            a = DW'(words[$urandom_range(0, 15)] * 4);
            if ($urandom_range(0, 3) == 0) a = a + DW'($urandom_range(1, 3));
            if (r >= 92) begin
                a = $urandom;
                if (a < DW'(4 * DEPTH)) a = a + DW'(4 * DEPTH);
            end
            if (r < 45 || (r >= 92 && r[0])) do_op(1'b1, 1'b0, a, $urandom, r[1]);
            else if (r < 85 || r >= 92)      do_op(1'b0, 1'b1, a, $urandom, r[1]);
            else                             do_op(1'b1, 1'b1, a, $urandom, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
